// File: rtl/sub4_result_fifo_if.sv
// Handshake bundle between the subtractor (producer), the result FIFO and its consumer.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface sub4_result_fifo_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             Co;
  logic             Overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_co;
  logic             out_overflow;

  modport slave (
    input  in_valid, result, Co, Overflow, out_ready,
    output in_ready, out_valid, out_result, out_co, out_overflow
  );

  modport master (
    output in_valid, result, Co, Overflow, out_ready,
    input  in_ready, out_valid, out_result, out_co, out_overflow
  );
endinterface

// File: rtl/sub4_result_fifo.sv
// First-word-fall-through FIFO for subtractor results with a saturating overflow tally.
// Define SUB4_FIFO_STICKY_OVF_EN to add a sticky overflow flag (ovf_clear / ovf_seen).
module sub4_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  sub4_result_fifo_if.slave bus,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  ovf_count
`ifdef SUB4_FIFO_STICKY_OVF_EN
  ,
  input  logic              ovf_clear,
  output logic              ovf_seen
`endif
);
  localparam int ENT_W = WIDTH + 2;

  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]            level_q, level_d;
  logic [CNT_W-1:0]            ovf_cnt_q, ovf_cnt_d;
  logic [DEPTH-1:0][ENT_W-1:0] ent_all;
  logic [ENT_W-1:0]            head;
  logic [ENT_W-1:0]            wr_data;
  logic                        push;
  logic                        pop;

  // Full/empty come from the level count so a wrapped pointer pair is never ambiguous.
  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = bus.in_valid && !full;
  assign pop     = bus.out_ready && !empty;
  assign wr_data = {bus.result, bus.Co, bus.Overflow};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_cnt_d = ovf_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    if (push && bus.Overflow && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage carries no reset; stale contents are masked by the empty check on the read side.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ENT_W-1:0] ent_q;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          ent_q <= wr_data;
        end
      end
      assign ent_all[gi] = ent_q;
    end
  endgenerate

  assign head = ent_all[rd_ptr_q];

  always_comb begin
    bus.in_ready     = !full;
    bus.out_valid    = !empty;
    bus.out_result   = '0;
    bus.out_co       = 1'b0;
    bus.out_overflow = 1'b0;
    if (!empty) begin
      bus.out_result   = head[ENT_W-1:2];
      bus.out_co       = head[1];
      bus.out_overflow = head[0];
    end
  end

  assign level     = level_q;
  assign ovf_count = ovf_cnt_q;

`ifdef SUB4_FIFO_STICKY_OVF_EN
  logic ovf_seen_q, ovf_seen_d;

  // A same-cycle overflow push beats a clear request.
  always_comb begin
    ovf_seen_d = ovf_seen_q;
    if (ovf_clear) begin
      ovf_seen_d = 1'b0;
    end
    if (push && bus.Overflow) begin
      ovf_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_seen_q <= 1'b0;
    end else begin
      ovf_seen_q <= ovf_seen_d;
    end
  end

  assign ovf_seen = ovf_seen_q;
`endif
endmodule

// File: tb/tb_sub4_result_fifo.sv
// Randomised self-checking bench for sub4_result_fifo against a queue-based reference model.
// Drives a default instance and a CNT_W=2 instance in lockstep to exercise counter saturation.
module tb_sub4_result_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sub4_result_fifo_if #(.WIDTH(WIDTH)) bus0 ();
  sub4_result_fifo_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.result    = bus0.result;
  assign bus1.Co        = bus0.Co;
  assign bus1.Overflow  = bus0.Overflow;
  assign bus1.out_ready = bus0.out_ready;

  logic [2:0] level0, level1;
  logic       full0, empty0, full1, empty1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
`ifdef SUB4_FIFO_STICKY_OVF_EN
  logic       ovf_clear = 1'b0;
  logic       seen0, seen1;
`endif

  sub4_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .level     (level0),
    .full      (full0),
    .empty     (empty0),
    .ovf_count (cnt0)
`ifdef SUB4_FIFO_STICKY_OVF_EN
    ,
    .ovf_clear (ovf_clear),
    .ovf_seen  (seen0)
`endif
  );

  sub4_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut_c2 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .level     (level1),
    .full      (full1),
    .empty     (empty1),
    .ovf_count (cnt1)
`ifdef SUB4_FIFO_STICKY_OVF_EN
    ,
    .ovf_clear (ovf_clear),
    .ovf_seen  (seen1)
`endif
  );

  // Reference model: queue of {result, co, ovf} packed as result*4 + co*2 + ovf.
  int q[$];
  int cnt8;
  int cnt2;
  int seen;
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int hd;
    int n;
    n  = q.size();
    hd = (n > 0) ? q[0] : 0;
    check_eq("level",        32'(level0),            n);
    check_eq("level_c2",     32'(level1),            n);
    check_eq("full",         32'(full0),             (n == DEPTH) ? 1 : 0);
    check_eq("empty",        32'(empty0),            (n == 0) ? 1 : 0);
    check_eq("full_c2",      32'(full1),             (n == DEPTH) ? 1 : 0);
    check_eq("empty_c2",     32'(empty1),            (n == 0) ? 1 : 0);
    check_eq("in_ready",     32'(bus0.in_ready),     (n < DEPTH) ? 1 : 0);
    check_eq("out_valid",    32'(bus0.out_valid),    (n > 0) ? 1 : 0);
    check_eq("out_result",   32'(bus0.out_result),   hd / 4);
    check_eq("out_co",       32'(bus0.out_co),       (hd / 2) % 2);
    check_eq("out_overflow", 32'(bus0.out_overflow), hd % 2);
    check_eq("out_result_c2", 32'(bus1.out_result),  hd / 4);
    check_eq("ovf_count",    32'(cnt0),              cnt8);
    check_eq("ovf_count_c2", 32'(cnt1),              cnt2);
`ifdef SUB4_FIFO_STICKY_OVF_EN
    check_eq("ovf_seen",     32'(seen0),             seen);
    check_eq("ovf_seen_c2",  32'(seen1),             seen);
`endif
  endtask

  task automatic step(input bit iv, input int r, input bit co, input bit ov,
                      input bit ordy, input bit rst, input bit clr);
    bit acc;
    bit pp;
    int popped;
    bus0.in_valid  = iv;
    bus0.result    = 4'(r);
    bus0.Co        = co;
    bus0.Overflow  = ov;
    bus0.out_ready = ordy;
    reset          = rst;
`ifdef SUB4_FIFO_STICKY_OVF_EN
    ovf_clear      = clr;
`endif
    #1;
    check_state();
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt8 = 0;
      cnt2 = 0;
      seen = 0;
      $display("reset (in_valid=%0d out_ready=%0d ignored)", iv, ordy);
    end else begin
      acc = iv && (q.size() < DEPTH);
      pp  = ordy && (q.size() > 0);
      if (pp) begin
        popped = q.pop_front();
        $display("pop  result=%h co=%0d ovf=%0d", popped / 4, (popped / 2) % 2, popped % 2);
      end
      if (acc) begin
        q.push_back((r % 16) * 4 + int'(co) * 2 + int'(ov));
        if (ov) begin
          cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
          cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
        end
        $display("push result=%h co=%0d ovf=%0d level=%0d", r % 16, co, ov, q.size());
      end else if (iv) begin
        $display("push refused result=%h (full)", r % 16);
      end
      if (clr) seen = 0;
      if (acc && ov) seen = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus0.in_valid  = 1'b0;
    bus0.result    = '0;
    bus0.Co        = 1'b0;
    bus0.Overflow  = 1'b0;
    bus0.out_ready = 1'b0;
    reset          = 1'b1;
    q.delete();
    cnt8 = 0;
    cnt2 = 0;
    seen = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (3) idle();

    // Fill to full, then one refused push.
    step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Level 2 then six simultaneous push/pop cycles across the pointer wrap.
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Overflow pushes: saturation on the narrow counter, then a refused overflow push.
    for (int i = 0; i < 5; i++) step(1'b1, i + 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset at level 3 with push and pop requested in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, i + 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
